// File: rtl/sequence_player.sv
// Plays the stored button sequence out on the four LEDs, one timed step at a time.
// Each step is lit for ON_CYCLES cycles, then dark for OFF_CYCLES cycles; done pulses after the last gap.
module sequence_player #(
  parameter int SEQ_LEN    = 5,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] round_len,
  input  logic [1:0]       correct_memory [SEQ_LEN],
  output logic [3:0]       leds,
  output logic [IDX_W-1:0] play_index,
  output logic             busy,
  output logic             done
);

  localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(SEQ_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [IDX_W-1:0] len, len_n;
  logic [IDX_W-1:0] idx_n;
  logic [3:0]       leds_n;
  logic             busy_n, done_n;
  logic [IDX_W-1:0] clamped_len;

  function automatic logic [3:0] onehot(input logic [1:0] sym);
    return 4'b0001 << sym;
  endfunction

  assign clamped_len = (round_len > LEN_MAX) ? LEN_MAX : round_len;

  // NOTE: every next-value signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    timer_n = timer;
    len_n   = len;
    idx_n   = play_index;
    leds_n  = leds;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        // abort outranks start even while idle
        if (start && !abort) begin
          len_n = clamped_len;
          idx_n = '0;
          if (clamped_len == '0) begin
            state_n = DONE;
            leds_n  = 4'b0000;
          end else begin
            state_n = ON;
            timer_n = ON_LOAD;
            leds_n  = onehot(correct_memory[0]);
          end
        end
      end

      ON: begin
        if (abort) begin
          state_n = IDLE;
          leds_n  = 4'b0000;
        end else if (timer == '0) begin
          state_n = OFF;
          timer_n = OFF_LOAD;
          leds_n  = 4'b0000;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      OFF: begin
        if (abort) begin
          state_n = IDLE;
          leds_n  = 4'b0000;
        end else if (timer == '0) begin
          if (play_index == len - 1'b1) begin
            state_n = DONE;
            leds_n  = 4'b0000;
          end else begin
            // symbol is captured here, so later memory writes cannot disturb this step
            idx_n   = play_index + 1'b1;
            state_n = ON;
            timer_n = ON_LOAD;
            leds_n  = onehot(correct_memory[play_index + 1'b1]);
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
        leds_n  = 4'b0000;
      end

      default: begin
        state_n = IDLE;
        leds_n  = 4'b0000;
      end
    endcase

    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      len        <= '0;
      play_index <= '0;
      leds       <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      len        <= len_n;
      play_index <= idx_n;
      leds       <= leds_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with short step timing (ON=3, OFF=2).
// Expected LED/done/busy/index values come from the fixed sequence and the step arithmetic.
module tb_sequence_player;

  localparam int SEQ_LEN = 5;
  localparam int ON_C    = 3;
  localparam int OFF_C   = 2;
  localparam int STEP_C  = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] round_len;
  logic [1:0] mem [SEQ_LEN];
  logic [3:0] leds;
  logic [2:0] play_index;
  logic       busy;
  logic       done;

  logic [1:0] ref_mem [SEQ_LEN];

  int n_checks = 0;
  int n_errors = 0;

  sequence_player #(
    .SEQ_LEN   (SEQ_LEN),
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .IDX_W     (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .round_len     (round_len),
    .correct_memory(mem),
    .leds          (leds),
    .play_index    (play_index),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".leds"}, 32'(leds), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".done"}, 32'(done), 32'h0);
  endtask

  // Pulse start, then check every cycle up to one past done.
  // again_at: cycle at which a second start is raised (0 = none).
  // mem_at: cycle at which mem[1] is corrupted for two cycles (0 = none).
  task automatic run_play(input string tag, input logic [2:0] rl, input int exp_len,
                          input int again_at, input int mem_at);
    int total;
    int s;
    int ph;
    logic [3:0] e_leds;
    logic [2:0] e_idx;
    total     = exp_len * STEP_C + 2;
    round_len = rl;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= total; c++) begin
      s  = (c - 1) / STEP_C;
      ph = (c - 1) % STEP_C;
      e_leds = (s < exp_len && ph < ON_C) ? (4'b0001 << ref_mem[s]) : 4'b0000;
      if (exp_len == 0)      e_idx = 3'd0;
      else if (s < exp_len)  e_idx = 3'(s);
      else                   e_idx = 3'(exp_len - 1);
      check($sformatf("%s.c%0d.leds", tag, c), 32'(leds), 32'(e_leds));
      check($sformatf("%s.c%0d.done", tag, c), 32'(done), 32'(c == exp_len * STEP_C + 1));
      check($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'(c <= exp_len * STEP_C + 1));
      check($sformatf("%s.c%0d.idx", tag, c), 32'(play_index), 32'(e_idx));
      if (c < total) begin
        start     = (c + 1 == again_at);
        round_len = (c + 1 == again_at) ? 3'd2 : rl;
        if (mem_at != 0 && c + 1 == mem_at)     mem[1] = 2'b11;
        if (mem_at != 0 && c + 1 == mem_at + 2) mem[1] = ref_mem[1];
        step();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    ref_mem[0] = 2'b00;
    ref_mem[1] = 2'b01;
    ref_mem[2] = 2'b00;
    ref_mem[3] = 2'b10;
    ref_mem[4] = 2'b11;
    for (int i = 0; i < SEQ_LEN; i++) mem[i] = ref_mem[i];
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    round_len = 3'd0;
    step();
    step();
    reset = 1'b0;

    // Idle after reset with no start
    for (int i = 0; i < 20; i++) begin
      check_idle($sformatf("rst.c%0d", i));
      check($sformatf("rst.c%0d.idx", i), 32'(play_index), 32'h0);
      step();
    end

    run_play("full", 3'd5, 5, 0, 0);
    run_play("part2", 3'd2, 2, 0, 0);
    run_play("clamp7", 3'd7, 5, 0, 0);
    run_play("len0", 3'd0, 0, 0, 0);
    run_play("restart_mem", 3'd5, 5, 6, 7);

    // Abort during step 1 ON window (cycle 8)
    round_len = 3'd5;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    check("abort.c8.leds", 32'(leds), 32'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort.c9");
    for (int c = 10; c < 16; c++) begin
      check_idle($sformatf("abort.c%0d", c));
      step();
    end
    // abort together with start in IDLE: start ignored
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_start");
    run_play("after_abort", 3'd5, 5, 0, 0);

    // Async reset in the middle of step 1 OFF (cycle 9), between clock edges
    round_len = 3'd5;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 9; c++) step();
    check("areset.pre.idx", 32'(play_index), 32'h1);
    check("areset.pre.busy", 32'(busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("areset.now");
    check("areset.now.idx", 32'(play_index), 32'h0);
    step();
    #2;
    reset = 1'b0;
    step();
    check_idle("areset.post");
    run_play("after_reset", 3'd1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
